// File: rtl/tile_regfile_pkg.sv
// Shared defaults, row/element types and index helpers for the tile
// register file and its transaction sequencer.
package tile_regfile_pkg;

  localparam int unsigned N_DEF      = 4;
  localparam int unsigned L_DEF      = 16;
  localparam int unsigned N_REGS_DEF = 16;
  localparam int unsigned NW_DEF     = 3;
  localparam int unsigned NR_DEF     = 3;

  typedef logic [L_DEF-1:0] elem_t;
  typedef elem_t [N_DEF-1:0] row_t;
  typedef logic [$clog2(N_REGS_DEF)-1:0] sel_t;

  // Bit offset of element j inside a packed row of l-bit elements.
  function automatic int unsigned elem_lsb(
    input int unsigned j,
    input int unsigned l
  );
    return j * l;
  endfunction

  function automatic int unsigned last_beat(
    input int unsigned n
  );
    return n - 1;
  endfunction

endpackage

// File: rtl/tile_regfile_seq.sv
// Transaction sequencer: beat counter, busy/done, start acceptance and
// the select/enable latches that hold a transaction's beat-0 controls.
module tile_regfile_seq
  import tile_regfile_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned NW = NW_DEF,
  parameter int unsigned NR = NR_DEF,
  parameter int unsigned SW = 4,
  parameter int unsigned CW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [NW-1:0]    wr_en,
  input  logic [NW*SW-1:0] wr_sel,
  input  logic [NR-1:0]    rd_en,
  input  logic [NR*SW-1:0] rd_sel,
  input  logic [NR-1:0]    rd_tr,
  output logic           active,
  output logic [CW-1:0]  beat,
  output logic [NW-1:0]    wr_en_b,
  output logic [NW*SW-1:0] wr_sel_b,
  output logic [NR-1:0]    rd_en_b,
  output logic [NR*SW-1:0] rd_sel_b,
  output logic [NR-1:0]    rd_tr_b,
  output logic           busy,
  output logic           done
);

  logic [CW-1:0]    cnt;
  logic             live;
  logic             last;
  logic             accept;
  logic [NW-1:0]    wr_en_q;
  logic [NW*SW-1:0] wr_sel_q;
  logic [NR-1:0]    rd_en_q;
  logic [NR*SW-1:0] rd_sel_q;
  logic [NR-1:0]    rd_tr_q;

  assign live   = start & ~busy;
  assign last   = busy & (cnt == CW'(last_beat(N)));
  assign accept = start & (~busy | last);
  assign active = rst_n & (start | busy);
  assign beat   = busy ? cnt : '0;
  assign done   = last;

  // Beat 0 of an idle-start runs on live controls; all others on latches.
  assign wr_en_b  = live ? wr_en  : wr_en_q;
  assign wr_sel_b = live ? wr_sel : wr_sel_q;
  assign rd_en_b  = live ? rd_en  : rd_en_q;
  assign rd_sel_b = live ? rd_sel : rd_sel_q;
  assign rd_tr_b  = live ? rd_tr  : rd_tr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      busy     <= 1'b0;
      wr_en_q  <= '0;
      wr_sel_q <= '0;
      rd_en_q  <= '0;
      rd_sel_q <= '0;
      rd_tr_q  <= '0;
    end else begin
      if (accept) begin
        wr_en_q  <= wr_en;
        wr_sel_q <= wr_sel;
        rd_en_q  <= rd_en;
        rd_sel_q <= rd_sel;
        rd_tr_q  <= rd_tr;
      end
      if (live) begin
        busy <= 1'b1;
        cnt  <= CW'(1);
      end else if (last) begin
        busy <= start;
        cnt  <= '0;
      end else if (busy) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tile_regfile.sv
// Multi-port NxN tile register file with row/column streaming reads.
// Optional `RD_BYPASS_EN forwards same-beat writes to non-transposed reads.
module tile_regfile
  import tile_regfile_pkg::*;
#(
  parameter int unsigned N      = N_DEF,
  parameter int unsigned L      = L_DEF,
  parameter int unsigned N_REGS = N_REGS_DEF,
  parameter int unsigned NW     = NW_DEF,
  parameter int unsigned NR     = NR_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [NW-1:0]                       wr_en,
  input  logic [NW*$clog2(N_REGS)-1:0]        wr_sel,
  input  logic [NW*N*L-1:0]                   wr_data,
  input  logic [NR-1:0]                       rd_en,
  input  logic [NR*$clog2(N_REGS)-1:0]        rd_sel,
  input  logic [NR-1:0]                       rd_tr,
  output logic [NR*N*L-1:0]                   rd_data,
  output logic [NR-1:0]                       rd_valid,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned W  = N * L;
  localparam int unsigned SW = $clog2(N_REGS);
  localparam int unsigned CW = $clog2(N);

  logic             active;
  logic [CW-1:0]    beat;
  logic [NW-1:0]    wr_en_b;
  logic [NW*SW-1:0] wr_sel_b;
  logic [NR-1:0]    rd_en_b;
  logic [NR*SW-1:0] rd_sel_b;
  logic [NR-1:0]    rd_tr_b;

  logic [W-1:0] mem [N_REGS][N];

  tile_regfile_seq #(
    .N  (N),
    .NW (NW),
    .NR (NR),
    .SW (SW),
    .CW (CW)
  ) u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .rd_en    (rd_en),
    .rd_sel   (rd_sel),
    .rd_tr    (rd_tr),
    .active   (active),
    .beat     (beat),
    .wr_en_b  (wr_en_b),
    .wr_sel_b (wr_sel_b),
    .rd_en_b  (rd_en_b),
    .rd_sel_b (rd_sel_b),
    .rd_tr_b  (rd_tr_b),
    .busy     (busy),
    .done     (done)
  );

  // Later ports are written last, so the highest index wins a collision.
  always_ff @(posedge clk) begin
    if (active) begin
      for (int p = 0; p < NW; p++) begin
        if (wr_en_b[p])
          mem[wr_sel_b[p*SW +: SW]][beat] <= wr_data[p*W +: W];
      end
    end
  end

  for (genvar p = 0; p < NR; p++) begin : g_rd
    logic [SW-1:0] s;
    logic [W-1:0]  row;
    logic [W-1:0]  col;
    logic [W-1:0]  nxt;
    logic [W-1:0]  data_q;
    logic          valid_q;

    assign s   = rd_sel_b[p*SW +: SW];
    assign row = mem[s][beat];

    always_comb begin
      col = '0;
      for (int j = 0; j < N; j++)
        col[elem_lsb(j, L) +: L] =
          mem[s][j][elem_lsb(32'(beat), L) +: L];
    end

`ifdef RD_BYPASS_EN
    logic         hit;
    logic [W-1:0] byp;

    always_comb begin
      hit = 1'b0;
      byp = '0;
      for (int q = 0; q < NW; q++) begin
        if (wr_en_b[q] && (wr_sel_b[q*SW +: SW] == s)) begin
          hit = 1'b1;
          byp = wr_data[q*W +: W];
        end
      end
    end

    assign nxt = rd_tr_b[p] ? col : (hit ? byp : row);
`else
    assign nxt = rd_tr_b[p] ? col : row;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= active & rd_en_b[p];
        if (active & rd_en_b[p])
          data_q <= nxt;
      end
    end

    assign rd_data[p*W +: W] = data_q;
    assign rd_valid[p]       = valid_q;
  end

endmodule

// File: doc/tile_regfile.md
Name: tile_regfile

Overview:
Parametrised successor of the NxN tile register file feeding the systolic MAC array. Holds N_REGS tiles of NxN L-bit elements; one tile transfers as N row beats. Generalises port count (NW write, NR read), adds per-read transpose, a start/busy/done transaction sequencer, and registered read data with per-port valid.

Parameters:
N, 4, tile dimension; rows per tile, elements per row (>=2)
L, 16, element width in bits
N_REGS, 16, tiles stored; power of 2
NW, 3, write ports
NR, 3, read ports
localparam W = N*L, row/column beat width
localparam SW = $clog2(N_REGS), tile select width
localparam CW = $clog2(N), beat counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin an N-beat transaction this cycle
wr_en  in  NW  per-write-port enable, sampled at start
wr_sel  in  NW*SW  per-port target tile, sampled at start
wr_data  in  NW*W  per-port row data for current beat, element 0 in LSBs
rd_en  in  NR  per-read-port enable, sampled at start
rd_sel  in  NR*SW  per-port source tile, sampled at start
rd_tr  in  NR  per-port transpose: 1 = stream columns, 0 = rows; sampled at start
rd_data  out  NR*W  per-port registered beat data
rd_valid  out  NR  per-port data-valid
busy  out  1  transaction in progress (beats 1..N-1)
done  out  1  one-cycle pulse on final beat

Behaviour:
- Reset (async assert, sync release): beat counter 0, busy 0, done 0, rd_valid 0, rd_data 0, latched selects/enables 0. Tile storage NOT reset; contents undefined until written.
- Beat 0 = start cycle; uses live wr_en/wr_sel/rd_en/rd_sel/rd_tr and latches them. Beats 1..N-1 use latched values; live select inputs ignored.
- active = (start & ~busy) | busy. Beat index k = 0 on start, else counter.
- busy: set after beat 0, cleared after beat N-1. done high combinationally-free (registered-equivalent) during beat N-1 cycle.
- start while busy ignored, except start during final beat (done=1) accepted: next cycle is beat 0 of new transaction, busy stays 1, no bubble.
- Write: on active beat k, each enabled port p writes wr_data[p] to row k of tile wr_sel[p]. Same tile from two ports: highest port index wins. Writes visible to reads next cycle.
- Read: on active beat k, enabled port p captures row k (rd_tr=0) or column k (rd_tr=1; element j = row j, col k) of tile rd_sel[p] into rd_data[p]; rd_valid[p]=1 next cycle. Latency 1 cycle; valid for exactly N consecutive cycles per transaction.
- Read of a row written in the same beat returns old contents (unless RD_BYPASS_EN).
- Disabled read ports: rd_valid 0, rd_data holds last value.
- Reset mid-transaction: aborts immediately; partial writes kept; no done.
- N=2 corner: busy high one cycle; done on beat 1.

Optional Feature:
RD_BYPASS_EN: defined -> non-transposed read of tile/row being written same beat returns the winning write data (highest port). Transposed reads never bypass. Undefined -> old data returned, no bypass muxes.

Decomposition:
- Package tile_regfile_pkg: element typedef (logic [L-1:0]), row typedef (N elements), tile-select typedef, helper to pack/unpack rows and extract column k.
- Sub-module tile_regfile_seq: beat counter, busy/done, start acceptance, select/enable latches. Storage and port datapath in top.

Test Plan:
- Write tile 5 port0 rows {0x0003_0002_0001_0000,...} one transaction; read tile 5 port1 rd_tr=0 -> rd_valid cycles 1..4, data equals rows in order; done at cycle 3.
- Read tile 5 port2 rd_tr=1 -> beat k returns column k, e.g. beat 0 = {0x000C,0x0008,0x0004,0x0000}.
- Ports 0 and 2 both write tile 7 with 0xAAAA.. / 0x5555.. -> readback 0x5555.. every row.
- start asserted on done cycle of back-to-back transactions -> busy continuous, 8 rd_valid cycles no gap; start mid-transaction (beat 2) ignored.
- rst_n low at beat 2 -> busy/done/rd_valid 0 immediately; rows 0-1 hold new data, rows 2-3 old.
- Same-beat write+read tile 3 row 0, rd_tr=0: without RD_BYPASS_EN old value; with it new value; rd_tr=1 old in both.
